// File: rtl/ecg_synth_pkg.sv
// Shared types and constants for the synthetic ECG generator.
// State order follows the P-QRS-T sequence of one beat.
package ecg_synth_pkg;

  typedef enum logic [3:0] {
    ECG_IDLE = 4'd0,
    ECG_P    = 4'd1,
    ECG_PR   = 4'd2,
    ECG_Q    = 4'd3,
    ECG_RU   = 4'd4,
    ECG_RD   = 4'd5,
    ECG_S    = 4'd6,
    ECG_ST   = 4'd7,
    ECG_T    = 4'd8,
    ECG_TP   = 4'd9
  } ecg_state_e;

  localparam int ECG_BASELINE = 512;
  localparam int ECG_MIN_QRS  = 4;

endpackage

// File: rtl/ecg_seg_len.sv
// Segment lengths for one beat, derived from the latched R-R interval and QRS width.
// Flags a beat period shorter than the fixed segments, or a QRS narrower than the minimum.
module ecg_seg_len
  import ecg_synth_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int P_LEN  = 20,
  parameter int PR_LEN = 16,
  parameter int ST_LEN = 24,
  parameter int T_LEN  = 40
) (
  input  logic [CNT_W-1:0] rr_q,
  input  logic [CNT_W-1:0] qw_q,
  output logic [CNT_W-1:0] q_len,
  output logic [CNT_W-1:0] s_len,
  output logic [CNT_W-1:0] tp_len,
  output logic             len_err
);

  localparam logic [CNT_W-1:0] MIN_QW  = CNT_W'(ECG_MIN_QRS);
  localparam logic [CNT_W:0]   FIXED_C = (CNT_W+1)'(P_LEN + PR_LEN + ST_LEN + T_LEN);

  logic             qw_small;
  logic [CNT_W-1:0] qw_eff;
  logic [CNT_W-1:0] q4;
  logic [CNT_W:0]   fixed_len;
  logic             rr_short;

  assign qw_small  = (qw_q < MIN_QW);
  assign qw_eff    = qw_small ? MIN_QW : qw_q;
  assign q4        = qw_eff >> 2;
  assign q_len     = q4;
  // S takes the remainder so Q+RU+RD+S always equals the effective QRS width.
  assign s_len     = qw_eff - (q4 + (q4 << 1));
  assign fixed_len = FIXED_C + {1'b0, qw_eff};
  assign rr_short  = ({1'b0, rr_q} < fixed_len);
  assign tp_len    = rr_short ? '0 : (rr_q - fixed_len[CNT_W-1:0]);
  assign len_err   = rr_short | qw_small;

endmodule

// File: rtl/ecg_synth.sv
// Piecewise-linear P-QRS-T sample generator, one sample per tick, with
// ground-truth beat-start and R-apex markers for checking a downstream detector.
module ecg_synth
  import ecg_synth_pkg::*;
#(
  parameter int DATA_W   = 11,
  parameter int CNT_W    = 12,
  parameter int BASELINE = ECG_BASELINE,
  parameter int P_LEN    = 20,
  parameter int PR_LEN   = 16,
  parameter int ST_LEN   = 24,
  parameter int T_LEN    = 40,
  parameter int P_STEP   = 2,
  parameter int R_STEP   = 40,
  parameter int QS_STEP  = 10,
  parameter int T_STEP   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              en,
  input  logic [CNT_W-1:0]  rr_len,
  input  logic [CNT_W-1:0]  qrs_w,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic              beat_start,
  output logic              r_mark,
  output logic              rr_err
);

  localparam logic [DATA_W-1:0] BASE_D   = DATA_W'(BASELINE);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  P_LEN_C  = CNT_W'(P_LEN);
  localparam logic [CNT_W-1:0]  PR_LEN_C = CNT_W'(PR_LEN);
  localparam logic [CNT_W-1:0]  ST_LEN_C = CNT_W'(ST_LEN);
  localparam logic [CNT_W-1:0]  T_LEN_C  = CNT_W'(T_LEN);
  localparam logic [CNT_W-1:0]  P_HALF   = CNT_W'(P_LEN / 2);
  localparam logic [CNT_W-1:0]  T_HALF   = CNT_W'(T_LEN / 2);
  localparam logic [DATA_W:0]   P_STP    = (DATA_W+1)'(P_STEP);
  localparam logic [DATA_W:0]   R_STP    = (DATA_W+1)'(R_STEP);
  localparam logic [DATA_W:0]   QS_STP   = (DATA_W+1)'(QS_STEP);
  localparam logic [DATA_W:0]   T_STP    = (DATA_W+1)'(T_STEP);

  function automatic logic [DATA_W-1:0] sat_up(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W:0] s);
    logic [DATA_W+1:0] t;
    t = {2'b00, a} + {1'b0, s};
    sat_up = (t[DATA_W+1:DATA_W] != 2'b00) ? '1 : t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_dn(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W:0] s);
    sat_dn = ({1'b0, a} > s) ? DATA_W'({1'b0, a} - s) : '0;
  endfunction

  ecg_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  seg_cnt_reg, seg_cnt_next;
  logic [CNT_W-1:0]  rr_q_reg, rr_q_next;
  logic [CNT_W-1:0]  qw_q_reg, qw_q_next;
  logic [DATA_W-1:0] d_reg, d_next;
  logic              d_valid_reg, d_valid_next;
  logic              beat_start_reg, beat_start_next;
  logic              r_mark_reg, r_mark_next;
  logic              rr_err_reg, rr_err_next;

  logic [CNT_W-1:0]  q_len, s_len, tp_len, seg_len;
  logic              len_err, seg_last, beat_done;

  ecg_seg_len #(
    .CNT_W  (CNT_W),
    .P_LEN  (P_LEN),
    .PR_LEN (PR_LEN),
    .ST_LEN (ST_LEN),
    .T_LEN  (T_LEN)
  ) u_seg_len (
    .rr_q    (rr_q_reg),
    .qw_q    (qw_q_reg),
    .q_len   (q_len),
    .s_len   (s_len),
    .tp_len  (tp_len),
    .len_err (len_err)
  );

  always_comb begin
    seg_len = ONE;
    case (state_reg)
      ECG_P:                 seg_len = P_LEN_C;
      ECG_PR:                seg_len = PR_LEN_C;
      ECG_Q, ECG_RU, ECG_RD: seg_len = q_len;
      ECG_S:                 seg_len = s_len;
      ECG_ST:                seg_len = ST_LEN_C;
      ECG_T:                 seg_len = T_LEN_C;
      ECG_TP:                seg_len = tp_len;
      default:               seg_len = ONE;
    endcase
  end

  assign seg_last = (seg_cnt_reg == (seg_len - ONE));

  always_comb begin
    state_next      = state_reg;
    seg_cnt_next    = seg_cnt_reg;
    rr_q_next       = rr_q_reg;
    qw_q_next       = qw_q_reg;
    d_next          = d_reg;
    d_valid_next    = 1'b0;
    beat_start_next = 1'b0;
    r_mark_next     = 1'b0;
    rr_err_next     = rr_err_reg;
    beat_done       = 1'b0;

    if (tick) begin
      if (state_reg == ECG_IDLE) begin
        if (en) begin
          rr_q_next    = rr_len;
          qw_q_next    = qrs_w;
          state_next   = ECG_P;
          seg_cnt_next = '0;
        end
      end else begin
        d_valid_next    = 1'b1;
        beat_start_next = (state_reg == ECG_P) && (seg_cnt_reg == '0);
        r_mark_next     = (state_reg == ECG_RU) && seg_last;
        rr_err_next     = rr_err_reg | len_err;

        case (state_reg)
          ECG_P:   d_next = (seg_cnt_reg < P_HALF) ? sat_up(d_reg, P_STP) : sat_dn(d_reg, P_STP);
          ECG_Q:   d_next = sat_dn(d_reg, QS_STP);
          ECG_RU:  d_next = sat_up(d_reg, R_STP);
          ECG_RD:  d_next = sat_dn(d_reg, R_STP);
          ECG_S:   d_next = sat_up(d_reg, QS_STP);
          ECG_T:   d_next = (seg_cnt_reg < T_HALF) ? sat_up(d_reg, T_STP) : sat_dn(d_reg, T_STP);
          default: d_next = BASE_D;
        endcase

        seg_cnt_next = seg_last ? '0 : (seg_cnt_reg + ONE);
        if (seg_last) begin
          case (state_reg)
            ECG_P:   state_next = ECG_PR;
            ECG_PR:  state_next = ECG_Q;
            ECG_Q:   state_next = ECG_RU;
            ECG_RU:  state_next = ECG_RD;
            ECG_RD:  state_next = ECG_S;
            ECG_S:   state_next = ECG_ST;
            ECG_ST:  state_next = ECG_T;
            ECG_T: begin
              if (tp_len == '0) beat_done = 1'b1;
              else              state_next = ECG_TP;
            end
            ECG_TP:  beat_done = 1'b1;
            default: state_next = ECG_IDLE;
          endcase
        end

        // Relatching here lets consecutive beats run back to back with no gap sample.
        if (beat_done) begin
          if (en) begin
            rr_q_next  = rr_len;
            qw_q_next  = qrs_w;
            state_next = ECG_P;
          end else begin
            state_next = ECG_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ECG_IDLE;
      seg_cnt_reg    <= '0;
      rr_q_reg       <= '0;
      qw_q_reg       <= '0;
      d_reg          <= BASE_D;
      d_valid_reg    <= 1'b0;
      beat_start_reg <= 1'b0;
      r_mark_reg     <= 1'b0;
      rr_err_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      seg_cnt_reg    <= seg_cnt_next;
      rr_q_reg       <= rr_q_next;
      qw_q_reg       <= qw_q_next;
      d_reg          <= d_next;
      d_valid_reg    <= d_valid_next;
      beat_start_reg <= beat_start_next;
      r_mark_reg     <= r_mark_next;
      rr_err_reg     <= rr_err_next;
    end
  end

  assign d_out      = d_reg;
  assign d_valid    = d_valid_reg;
  assign beat_start = beat_start_reg;
  assign r_mark     = r_mark_reg;
  assign rr_err     = rr_err_reg;

endmodule

// File: tb/tb_ecg_synth.sv
// Directed bench for ecg_synth: waveform shape, beat timing, error flag, reset abort
// and saturation (second instance with a steep R slope).
module tb_ecg_synth;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        en = 1'b0;
  logic [11:0] rr_len = 12'd400;
  logic [11:0] qrs_w = 12'd16;

  logic [10:0] d_out, sat_d_out;
  logic        d_valid, beat_start, r_mark, rr_err;
  logic        sat_valid, sat_beat, sat_r_mark, sat_err;

  int total = 0;
  int bad = 0;
  int beat_q[$];
  int r_q[$];
  int samp_q[$];
  int sat_apex_q[$];
  int sat_after_q[$];
  bit sat_pending = 1'b0;
  int tick_div = 0;

  ecg_synth dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .en         (en),
    .rr_len     (rr_len),
    .qrs_w      (qrs_w),
    .d_out      (d_out),
    .d_valid    (d_valid),
    .beat_start (beat_start),
    .r_mark     (r_mark),
    .rr_err     (rr_err)
  );

  ecg_synth #(.R_STEP(400)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .en         (en),
    .rr_len     (rr_len),
    .qrs_w      (qrs_w),
    .d_out      (sat_d_out),
    .d_valid    (sat_valid),
    .beat_start (sat_beat),
    .r_mark     (sat_r_mark),
    .rr_err     (sat_err)
  );

  always #5 clk = ~clk;

  // Tick every 4th clock, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      tick = (tick_div == 0);
    end
  end

  // Sample log: every emitted sample, plus sample indices of the markers.
  always @(negedge clk) begin
    if (d_valid) begin
      if (beat_start) beat_q.push_back(samp_q.size());
      if (r_mark) r_q.push_back(samp_q.size());
      samp_q.push_back(int'(d_out));
    end
    if (sat_valid) begin
      if (sat_pending) begin
        sat_after_q.push_back(int'(sat_d_out));
        sat_pending = 1'b0;
      end
      if (sat_r_mark) begin
        sat_apex_q.push_back(int'(sat_d_out));
        sat_pending = 1'b1;
      end
    end
  end

  task automatic wait_beats(input int target, input string name);
    int n = 0;
    while (beat_q.size() < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (beat_q.size() < target) begin
      bad++;
      $display("FAIL %s timeout: beats=%0d required=%0d", name, beat_q.size(), target);
    end
  endtask

  task automatic wait_samples(input int target, input string name);
    int n = 0;
    while (samp_q.size() < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (samp_q.size() < target) begin
      bad++;
      $display("FAIL %s timeout: samples=%0d required=%0d", name, samp_q.size(), target);
    end
  endtask

  task automatic test_reset();
    int n0;
    rst = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total += 5;
    if (d_out !== 11'd512) begin bad++; $display("FAIL reset_d_out: got %0d expected 512", d_out); end
    if (d_valid !== 1'b0) begin bad++; $display("FAIL reset_d_valid: got %b expected 0", d_valid); end
    if (beat_start !== 1'b0) begin bad++; $display("FAIL reset_beat_start: got %b expected 0", beat_start); end
    if (r_mark !== 1'b0) begin bad++; $display("FAIL reset_r_mark: got %b expected 0", r_mark); end
    if (rr_err !== 1'b0) begin bad++; $display("FAIL reset_rr_err: got %b expected 0", rr_err); end
    @(negedge clk);
    rst = 1'b1;
    n0 = samp_q.size();
    repeat (40) @(negedge clk);
    #1;
    total += 2;
    if (samp_q.size() !== n0) begin bad++; $display("FAIL idle_no_samples: got %0d expected %0d", samp_q.size(), n0); end
    if (d_out !== 11'd512) begin bad++; $display("FAIL idle_d_out: got %0d expected 512", d_out); end
    $display("test_reset: idle samples=%0d d_out=%0d", samp_q.size() - n0, d_out);
  endtask

  task automatic test_normal();
    int nb, nr, b, mx, mn;
    @(negedge clk);
    rr_len = 12'd400;
    qrs_w = 12'd16;
    en = 1'b1;
    nb = beat_q.size();
    nr = r_q.size();
    wait_beats(nb + 4, "normal_beats");
    b = beat_q[nb];
    mx = 0;
    mn = 4096;
    for (int i = b; i < beat_q[nb+3]; i++) begin
      if (samp_q[i] > mx) mx = samp_q[i];
      if (samp_q[i] < mn) mn = samp_q[i];
    end
    total += 13;
    if (b !== 0) begin bad++; $display("FAIL first_beat_index: got %0d expected 0", b); end
    if (beat_q[nb+1] - b !== 400) begin bad++; $display("FAIL beat_space1: got %0d expected 400", beat_q[nb+1] - b); end
    if (beat_q[nb+2] - beat_q[nb+1] !== 400) begin bad++; $display("FAIL beat_space2: got %0d expected 400", beat_q[nb+2] - beat_q[nb+1]); end
    if (r_q[nr+1] - r_q[nr] !== 400) begin bad++; $display("FAIL r_space1: got %0d expected 400", r_q[nr+1] - r_q[nr]); end
    if (r_q[nr+2] - r_q[nr+1] !== 400) begin bad++; $display("FAIL r_space2: got %0d expected 400", r_q[nr+2] - r_q[nr+1]); end
    if (r_q[nr] - b !== 43) begin bad++; $display("FAIL r_offset: got %0d expected 43", r_q[nr] - b); end
    if (samp_q[r_q[nr]] !== 632) begin bad++; $display("FAIL apex_value: got %0d expected 632", samp_q[r_q[nr]]); end
    if (mx !== 632) begin bad++; $display("FAIL peak: got %0d expected 632", mx); end
    if (mn !== 472) begin bad++; $display("FAIL trough: got %0d expected 472", mn); end
    if (samp_q[b] !== 514) begin bad++; $display("FAIL p_first: got %0d expected 514", samp_q[b]); end
    if (samp_q[b+9] !== 532) begin bad++; $display("FAIL p_peak: got %0d expected 532", samp_q[b+9]); end
    if (samp_q[b+95] !== 572) begin bad++; $display("FAIL t_peak: got %0d expected 572", samp_q[b+95]); end
    if (rr_err !== 1'b0) begin bad++; $display("FAIL normal_rr_err: got %b expected 0", rr_err); end
    $display("test_normal: period=%0d peak=%0d trough=%0d", beat_q[nb+1] - b, mx, mn);
  endtask

  task automatic test_saturate();
    total += 3;
    if (sat_apex_q.size() < 1 || sat_after_q.size() < 1) begin
      bad++;
      $display("FAIL sat_capture: got %0d apexes expected at least 1", sat_apex_q.size());
    end
    if (sat_apex_q[0] !== 2047) begin bad++; $display("FAIL sat_apex: got %0d expected 2047", sat_apex_q[0]); end
    if (sat_after_q[0] !== 1647) begin bad++; $display("FAIL sat_after_apex: got %0d expected 1647", sat_after_q[0]); end
    $display("test_saturate: apex=%0d next=%0d", sat_apex_q[0], sat_after_q[0]);
  endtask

  task automatic test_mid_change();
    int nb;
    nb = beat_q.size();
    wait_beats(nb + 1, "mid_first");
    wait_samples(beat_q[nb] + 50, "mid_samples");
    rr_len = 12'd300;
    wait_beats(nb + 3, "mid_beats");
    total += 2;
    if (beat_q[nb+1] - beat_q[nb] !== 400) begin bad++; $display("FAIL mid_current: got %0d expected 400", beat_q[nb+1] - beat_q[nb]); end
    if (beat_q[nb+2] - beat_q[nb+1] !== 300) begin bad++; $display("FAIL mid_next: got %0d expected 300", beat_q[nb+2] - beat_q[nb+1]); end
    $display("test_mid_change: periods %0d then %0d", beat_q[nb+1] - beat_q[nb], beat_q[nb+2] - beat_q[nb+1]);
  endtask

  task automatic test_short_rr();
    int nb;
    nb = beat_q.size();
    wait_beats(nb + 1, "short_first");
    rr_len = 12'd100;
    wait_beats(nb + 3, "short_beats");
    rr_len = 12'd400;
    total += 3;
    if (beat_q[nb+1] - beat_q[nb] !== 300) begin bad++; $display("FAIL short_prev: got %0d expected 300", beat_q[nb+1] - beat_q[nb]); end
    if (beat_q[nb+2] - beat_q[nb+1] !== 116) begin bad++; $display("FAIL short_period: got %0d expected 116", beat_q[nb+2] - beat_q[nb+1]); end
    if (rr_err !== 1'b1) begin bad++; $display("FAIL short_rr_err: got %b expected 1", rr_err); end
    wait_beats(nb + 5, "short_restore");
    total += 3;
    if (beat_q[nb+3] - beat_q[nb+2] !== 116) begin bad++; $display("FAIL short_latched: got %0d expected 116", beat_q[nb+3] - beat_q[nb+2]); end
    if (beat_q[nb+4] - beat_q[nb+3] !== 400) begin bad++; $display("FAIL short_restored: got %0d expected 400", beat_q[nb+4] - beat_q[nb+3]); end
    if (rr_err !== 1'b1) begin bad++; $display("FAIL rr_err_sticky: got %b expected 1", rr_err); end
    $display("test_short_rr: period=%0d rr_err=%b", beat_q[nb+2] - beat_q[nb+1], rr_err);
  endtask

  task automatic test_drop_en();
    int nb, last_n, quiet, n;
    nb = beat_q.size();
    wait_beats(nb + 1, "drop_first");
    wait_samples(beat_q[nb] + 50, "drop_samples");
    en = 1'b0;
    last_n = samp_q.size();
    quiet = 0;
    n = 0;
    while (quiet < 40 && n < 5000) begin
      @(negedge clk);
      n++;
      if (samp_q.size() == last_n) quiet++;
      else begin quiet = 0; last_n = samp_q.size(); end
    end
    #1;
    total += 4;
    if (quiet < 40) begin bad++; $display("FAIL drop_stop: got %0d quiet clocks expected 40", quiet); end
    if (samp_q.size() - beat_q[nb] !== 400) begin bad++; $display("FAIL drop_complete: got %0d expected 400", samp_q.size() - beat_q[nb]); end
    if (beat_q.size() !== nb + 1) begin bad++; $display("FAIL drop_no_new_beat: got %0d expected %0d", beat_q.size(), nb + 1); end
    if (d_out !== 11'd512) begin bad++; $display("FAIL drop_d_out: got %0d expected 512", d_out); end
    $display("test_drop_en: last beat samples=%0d", samp_q.size() - beat_q[nb]);
  endtask

  task automatic test_reset_mid_r();
    int nb, b;
    rr_len = 12'd400;
    qrs_w = 12'd16;
    en = 1'b1;
    nb = beat_q.size();
    wait_beats(nb + 1, "rst_first");
    b = beat_q[nb];
    wait_samples(b + 42, "rst_samples");
    total += 2;
    if (samp_q[b+39] !== 472) begin bad++; $display("FAIL q_last: got %0d expected 472", samp_q[b+39]); end
    if (samp_q[b+41] !== 552) begin bad++; $display("FAIL ru_second: got %0d expected 552", samp_q[b+41]); end
    rst = 1'b0;
    #1;
    total += 4;
    if (d_out !== 11'd512) begin bad++; $display("FAIL rst_mid_d_out: got %0d expected 512", d_out); end
    if (d_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_d_valid: got %b expected 0", d_valid); end
    if (r_mark !== 1'b0) begin bad++; $display("FAIL rst_mid_r_mark: got %b expected 0", r_mark); end
    if (rr_err !== 1'b0) begin bad++; $display("FAIL rst_mid_rr_err: got %b expected 0", rr_err); end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("test_reset_mid_r: d_out after reset=%0d", d_out);
  endtask

  task automatic test_qrs_min();
    int nb, nr, b;
    @(negedge clk);
    rr_len = 12'd400;
    qrs_w = 12'd2;
    en = 1'b1;
    nb = beat_q.size();
    nr = r_q.size();
    wait_beats(nb + 3, "qmin_beats");
    b = beat_q[nb];
    total += 6;
    if (beat_q[nb+1] - b !== 400) begin bad++; $display("FAIL qmin_space1: got %0d expected 400", beat_q[nb+1] - b); end
    if (beat_q[nb+2] - beat_q[nb+1] !== 400) begin bad++; $display("FAIL qmin_space2: got %0d expected 400", beat_q[nb+2] - beat_q[nb+1]); end
    if (samp_q[b+36] !== 502) begin bad++; $display("FAIL qmin_trough: got %0d expected 502", samp_q[b+36]); end
    if (r_q[nr] - b !== 37) begin bad++; $display("FAIL qmin_r_offset: got %0d expected 37", r_q[nr] - b); end
    if (samp_q[r_q[nr]] !== 542) begin bad++; $display("FAIL qmin_apex: got %0d expected 542", samp_q[r_q[nr]]); end
    if (rr_err !== 1'b1) begin bad++; $display("FAIL qmin_rr_err: got %b expected 1", rr_err); end
    $display("test_qrs_min: apex=%0d rr_err=%b", samp_q[r_q[nr]], rr_err);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_saturate();
    test_mid_change();
    test_short_rr();
    test_drop_en();
    test_reset_mid_r();
    test_qrs_min();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
